// File: rtl/pec_psum_acc_ctrl.sv
// pec_psum_acc_ctrl: read-modify-write controller in front of the PE-column
// partial-sum RAM (single-port, 1-cycle read latency). Accumulates signed
// partial sums with saturation and drains the buffer as a valid/ready stream.
// Optional: define PEC_DRAIN_CLEAR_EN to zero each word after it is drained.
module pec_psum_acc_ctrl #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 28,
    parameter int IN_WIDTH   = 24
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [IN_WIDTH-1:0]   in_data,
    input  logic                  in_first,
    input  logic                  drain_req,
    input  logic [ADDR_WIDTH:0]   drain_len,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  drain_done,
    output logic                  sat_flag,
    output logic [ADDR_WIDTH-1:0] ram_addr_r,
    output logic [ADDR_WIDTH-1:0] ram_addr_w,
    output logic                  ram_read_en,
    output logic                  ram_write_en,
    output logic [DATA_WIDTH-1:0] ram_data_in,
    input  logic [DATA_WIDTH-1:0] ram_data_out
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int CW    = ADDR_WIDTH + 1;
    localparam logic [CW-1:0]         DEPTH_C = CW'(DEPTH);
    localparam logic [DATA_WIDTH-1:0] SMAX    = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] SMIN    = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_DRD,
        S_DCAP,
`ifdef PEC_DRAIN_CLEAR_EN
        S_DOUT,
        S_DCLR
`else
        S_DOUT
`endif
    } state_e;

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] sext_q;
    logic                  first_q;
    logic [CW-1:0]         len_q;
    logic [CW-1:0]         cnt_q;
    logic                  out_valid_q;
    logic [ADDR_WIDTH-1:0] out_addr_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic                  done_q;
    logic                  sat_q;

    logic [DATA_WIDTH:0]   sum;
    logic                  ovf;
    logic [DATA_WIDTH-1:0] acc_d;
    logic [DATA_WIDTH-1:0] in_sext;
    logic [CW-1:0]         len_d;
    logic [CW-1:0]         cnt_d;
    logic                  last;

    // Saturating add of the read-back word and the latched update, one extra bit
    // of headroom so the overflow direction is visible in the top bit.
    always_comb begin
        sum     = {ram_data_out[DATA_WIDTH-1], ram_data_out} + {sext_q[DATA_WIDTH-1], sext_q};
        ovf     = sum[DATA_WIDTH] ^ sum[DATA_WIDTH-1];
        acc_d   = ovf ? (sum[DATA_WIDTH] ? SMIN : SMAX) : sum[DATA_WIDTH-1:0];
        in_sext = {{(DATA_WIDTH-IN_WIDTH){in_data[IN_WIDTH-1]}}, in_data};
        len_d   = (drain_len > DEPTH_C) ? DEPTH_C : drain_len;
        cnt_d   = cnt_q + 1'b1;
        last    = (cnt_d == len_q);
    end

    // RAM strobes decode only from the state and latched fields, so the macro
    // never sees read and write together and nothing from in_* leaks through.
    always_comb begin
        in_ready     = (state_q == S_IDLE) & ~drain_req;
        ram_read_en  = (state_q == S_RD) || (state_q == S_DRD);
        ram_addr_r   = '0;
        ram_write_en = 1'b0;
        ram_addr_w   = '0;
        ram_data_in  = '0;
        if (state_q == S_RD)  ram_addr_r = addr_q;
        if (state_q == S_DRD) ram_addr_r = cnt_q[ADDR_WIDTH-1:0];
        if (state_q == S_WR) begin
            ram_write_en = 1'b1;
            ram_addr_w   = addr_q;
            ram_data_in  = first_q ? sext_q : acc_d;
        end
`ifdef PEC_DRAIN_CLEAR_EN
        if (state_q == S_DCLR) begin
            ram_write_en = 1'b1;
            ram_addr_w   = out_addr_q;
        end
`endif
    end

    assign out_valid  = out_valid_q;
    assign out_addr   = out_addr_q;
    assign out_data   = out_data_q;
    assign drain_done = done_q;
    assign sat_flag   = sat_q;

    // Main FSM: update RMW path, drain path and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            sext_q      <= '0;
            first_q     <= 1'b0;
            len_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
            done_q      <= 1'b0;
            sat_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // Drain has priority over a simultaneous update.
                    if (drain_req) begin
                        len_q <= len_d;
                        cnt_q <= '0;
                        sat_q <= 1'b0;
                        if (len_d == '0) done_q  <= 1'b1;
                        else             state_q <= S_DRD;
                    end else if (in_valid) begin
                        addr_q  <= in_addr;
                        sext_q  <= in_sext;
                        first_q <= in_first;
                        state_q <= in_first ? S_WR : S_RD;
                    end
                end
                S_RD:   state_q <= S_WR;
                S_WR: begin
                    if (!first_q && ovf) sat_q <= 1'b1;
                    state_q <= S_IDLE;
                end
                S_DRD:  state_q <= S_DCAP;
                S_DCAP: begin
                    out_data_q  <= ram_data_out;
                    out_addr_q  <= cnt_q[ADDR_WIDTH-1:0];
                    out_valid_q <= 1'b1;
                    state_q     <= S_DOUT;
                end
                S_DOUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
`ifdef PEC_DRAIN_CLEAR_EN
                        state_q <= S_DCLR;
`else
                        if (last) begin
                            done_q  <= 1'b1;
                            state_q <= S_IDLE;
                        end else begin
                            cnt_q   <= cnt_d;
                            state_q <= S_DRD;
                        end
`endif
                    end
                end
`ifdef PEC_DRAIN_CLEAR_EN
                S_DCLR: begin
                    if (last) begin
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q   <= cnt_d;
                        state_q <= S_DRD;
                    end
                end
`endif
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
